// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with
// registered sync, active-video and start-pulse outputs for the renderers.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COORD_W  = 10
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters must be able to hold the last pixel and last line index.
  if ((H_TOTAL > (2 ** COORD_W)) || (V_TOTAL > (2 ** COORD_W))) begin : g_width_check
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 or V_TOTAL-1");
  end

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] hc_q, hc_d;
  logic [COORD_W-1:0] vc_q, vc_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  // Next raster position, and every output decoded from that next position
  // so the registered outputs always agree with the registered counters.
  always_comb begin
    hc_d = hc_q + COORD_W'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + COORD_W'(1);
      end
    end
    blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_d          = !((hc_d >= HS_START) && (hc_d < HS_END));
    vs_d          = !((vc_d >= VS_START) && (vc_d < VS_END));
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  // Raster state; reset parks on the last pixel of the frame so the first
  // edge after release lands on (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance and a tiny-raster
// instance share clock and reset; expected outputs come from a pixel-index
// model and are checked by a scoreboard monitor on every falling edge.
module tb_vga_timing_gen;

  // Default raster
  localparam int B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
  localparam int B_VA = 480, B_VF = 10, B_VS = 2,  B_VB = 33;
  // Tiny raster so whole frames fit in a short run
  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 12, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_W  = 5;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit blank;
    bit ls;
    bit fs;
    bit rst;
  } exp_t;

  logic vga_clk = 1'b0;
  logic reset;
  bit   clk_run = 1'b0;

  logic       b_hs, b_vs, b_blank, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [S_W-1:0] s_x, s_y;

  exp_t exp_big[$];
  exp_t exp_small[$];
  event manual_sample;

  int checks = 0;
  int errors = 0;
  int p = -1;

  int  vs_run = 0;
  int  fs_gap = 0;
  int  ls_count = 0;
  bit  fs_seen = 1'b0;

  vga_timing_gen u_big (
    .vga_clk(vga_clk), .reset(reset), .hs(b_hs), .vs(b_vs), .blank(b_blank),
    .DrawX(b_x), .DrawY(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .COORD_W(S_W)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .DrawX(s_x), .DrawY(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  // Gated pixel clock so the first reset check sees no edges at all
  always begin
    #5;
    if (clk_run) vga_clk = ~vga_clk;
  end

  // Reference: pixel index since release maps straight to a raster position
  function automatic exp_t model(input int idx, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb);
    exp_t e;
    int ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (idx < 0) begin
      e.x = ht - 1; e.y = vt - 1;
      e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.rst = 1'b1;
    end else begin
      e.x     = idx % ht;
      e.y     = (idx / ht) % vt;
      e.blank = (e.x < ha) && (e.y < va);
      e.hs    = !((e.x >= ha + hf) && (e.x < ha + hf + hsw));
      e.vs    = !((e.y >= va + vf) && (e.y < va + vf + vsw));
      e.ls    = (e.x == 0);
      e.fs    = (e.x == 0) && (e.y == 0);
      e.rst   = 1'b0;
    end
    return e;
  endfunction

  task automatic pushExpected();
    exp_big.push_back(model(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB));
    exp_small.push_back(model(p, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
  endtask

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock: mode 0 = reset low after the edge, 1 = reset held high,
  // 2 = reset pulsed high between edges and released before the next edge
  task automatic applyStimulus(input int mode);
    @(posedge vga_clk);
    if (reset) p = -1;
    else p = p + 1;
    #2;
    if (mode == 0) begin
      reset = 1'b0;
    end else begin
      reset = 1'b1;
      p = -1;
    end
    pushExpected();
    if (mode == 2) begin
      @(negedge vga_clk);
      #2;
      reset = 1'b0;
    end
  endtask

  // Monitor: every sample point pops one expectation per instance
  always begin
    exp_t eb, es;
    @(negedge vga_clk or manual_sample);
    if (exp_big.size() == 0 || exp_small.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1 (t=%0t)", $time);
    end else begin
      eb = exp_big.pop_front();
      es = exp_small.pop_front();
      checkOutput("big.DrawX", int'(b_x), eb.x);
      checkOutput("big.DrawY", int'(b_y), eb.y);
      checkOutput("big.hs", int'(b_hs), int'(eb.hs));
      checkOutput("big.vs", int'(b_vs), int'(eb.vs));
      checkOutput("big.blank", int'(b_blank), int'(eb.blank));
      checkOutput("big.line_start", int'(b_ls), int'(eb.ls));
      checkOutput("big.frame_start", int'(b_fs), int'(eb.fs));
      checkOutput("small.DrawX", int'(s_x), es.x);
      checkOutput("small.DrawY", int'(s_y), es.y);
      checkOutput("small.hs", int'(s_hs), int'(es.hs));
      checkOutput("small.vs", int'(s_vs), int'(es.vs));
      checkOutput("small.blank", int'(s_blank), int'(es.blank));
      checkOutput("small.line_start", int'(s_ls), int'(es.ls));
      checkOutput("small.frame_start", int'(s_fs), int'(es.fs));
      if (es.rst) begin
        vs_run = 0; fs_gap = 0; ls_count = 0; fs_seen = 1'b0;
      end else begin
        if (!s_vs) begin
          vs_run++;
        end else if (vs_run > 0) begin
          checkOutput("small.vs_low_run", vs_run, S_VS * S_HT);
          vs_run = 0;
        end
        if (s_fs) begin
          if (fs_seen) begin
            checkOutput("small.frame_period", fs_gap, S_HT * S_VT);
            checkOutput("small.lines_per_frame", ls_count, S_VT);
          end
          fs_gap = 0;
          ls_count = 0;
          fs_seen = 1'b1;
        end
        if (s_ls) ls_count++;
        fs_gap++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    // Reset state with no clock edge ever seen
    p = -1;
    pushExpected();
    -> manual_sample;
    #4;
    clk_run = 1'b1;
    applyStimulus(1);
    applyStimulus(0);
    // First line, line wrap, and several full tiny frames
    for (int i = 0; i < 3000; i++) applyStimulus(0);
    // Random run lengths broken by held or between-edge reset pulses
    for (int k = 0; k < 20; k++) begin
      int len;
      len = $urandom_range(1500, 50);
      for (int i = 0; i < len; i++) applyStimulus(0);
      if ($urandom_range(1, 0) == 1) begin
        applyStimulus(2);
      end else begin
        int hold;
        hold = $urandom_range(3, 1);
        for (int i = 0; i < hold; i++) applyStimulus(1);
      end
    end
    for (int i = 0; i < 1500; i++) applyStimulus(0);
    @(negedge vga_clk);
    #2;
    clk_run = 1'b0;
    checkOutput("scoreboard_drained", exp_big.size() + exp_small.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
